// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter sequencer. It selects the next PC from the
//             sequential step, a conditional branch, an absolute jump, a
//             register jump, a return-address stack (RAS), exception return
//             and exception entry.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    in_CLOCK        in   1      rising-edge clock
//    in_RST_N        in   1      asynchronous reset, active low
//    in_EN           in   1      advance enable (low = stall)
//    in_BEQ/BNE/BGEZ in   1      conditional-branch decode
//    in_equal        in   1      ALU A==B
//    in_ge_zero      in   1      ALU A>=0 (signed)
//    in_J/JAL/JR     in   1      jump, jump-and-link, register jump
//    in_RET/ERET     in   1      return via RAS, exception return
//    in_force        in   1      exception/interrupt entry
//    in_faddr        in   WIDTH  exception handler address
//    in_extended     in   WIDTH  sign-extended branch offset (words)
//    in_a            in   WIDTH  register-jump target
//    in_is           in   32     current instruction word
//    out_pcout       out  WIDTH  registered PC
//    out_JS          out  1      combinational redirect / flush request
//    out_epc         out  WIDTH  registered exception PC
//    out_ras_top     out  WIDTH  RAS top entry, 0 when empty
//    out_ras_empty   out  1      RAS empty
//    out_ras_full    out  1      RAS full
//    out_ras_err     out  1      one-cycle pulse on RAS underflow
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               RAS_DEPTH  = 4,
  parameter int               INST_BYTES = 4
) (
  input  logic             in_CLOCK,
  input  logic             in_RST_N,
  input  logic             in_EN,
  input  logic             in_BEQ,
  input  logic             in_BNE,
  input  logic             in_BGEZ,
  input  logic             in_equal,
  input  logic             in_ge_zero,
  input  logic             in_J,
  input  logic             in_JAL,
  input  logic             in_JR,
  input  logic             in_RET,
  input  logic             in_ERET,
  input  logic             in_force,
  input  logic [WIDTH-1:0] in_faddr,
  input  logic [WIDTH-1:0] in_extended,
  input  logic [WIDTH-1:0] in_a,
  input  logic [31:0]      in_is,
  output logic [WIDTH-1:0] out_pcout,
  output logic             out_JS,
  output logic [WIDTH-1:0] out_epc,
  output logic [WIDTH-1:0] out_ras_top,
  output logic             out_ras_empty,
  output logic             out_ras_full,
  output logic             out_ras_err
);

  localparam int               PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] C_STEP    = WIDTH'(INST_BYTES);

  // Source of the next PC, resolved in strict priority order.
  typedef enum logic [3:0] {
    SRC_SEQ      = 4'd0,
    SRC_HOLD     = 4'd1,
    SRC_FORCE    = 4'd2,
    SRC_ERET     = 4'd3,
    SRC_RET      = 4'd4,
    SRC_RET_MISS = 4'd5,
    SRC_JR       = 4'd6,
    SRC_JUMP     = 4'd7,
    SRC_BRANCH   = 4'd8
  } src_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_q,  pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;   // next slot to write; top is ptr_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;   // valid entries, saturates at RAS_DEPTH
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  // --------------------------------------------------------------------------
  // Candidate targets
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] jmp_pc;
  logic [WIDTH-1:0] top_pc;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic             br_taken;
  src_e             src;

  // Bits that take no part in target formation.
  logic unused_bits;
  assign unused_bits = ^{in_is[31:26], in_extended[WIDTH-1:WIDTH-2]};

  assign seq_pc    = pc_q + C_STEP;
  assign br_pc     = seq_pc + {in_extended[WIDTH-3:0], 2'b00};
  assign jmp_pc    = {pc_q[WIDTH-1:28], in_is[25:0], 2'b00};
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == C_CNT_MAX);
  assign top_idx   = ptr_q - PTR_W'(1);
  assign top_pc    = ras_empty ? '0 : ras_q[top_idx];

  assign br_taken = (in_BEQ  &  in_equal)
                  | (in_BNE  & ~in_equal)
                  | (in_BGEZ &  in_ge_zero);

  // --------------------------------------------------------------------------
  // Source selection
  // --------------------------------------------------------------------------
  always_comb begin
    src = SRC_SEQ;
    if (in_force) begin
      src = SRC_FORCE;            // exception entry overrides a stall
    end else if (!in_EN) begin
      src = SRC_HOLD;
    end else if (in_ERET) begin
      src = SRC_ERET;
    end else if (in_RET) begin
      src = ras_empty ? SRC_RET_MISS : SRC_RET;
    end else if (in_JR) begin
      src = SRC_JR;
    end else if (in_J || in_JAL) begin
      src = SRC_JUMP;
    end else if (br_taken) begin
      src = SRC_BRANCH;
    end
  end

  // Any redirect away from the sequential stream needs a pipeline flush.
  assign out_JS = (src != SRC_SEQ) && (src != SRC_HOLD);

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_d[i] = ras_q[i];
    end

    case (src)
      SRC_FORCE: begin
        pc_d  = in_faddr;
        epc_d = pc_q;
      end
      SRC_HOLD: begin
        pc_d = pc_q;
      end
      SRC_ERET: begin
        pc_d = epc_q;
      end
      SRC_RET: begin
        pc_d  = top_pc;
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
      SRC_RET_MISS: begin
        // Underflow: fall back to the register target, stack untouched.
        pc_d  = in_a;
        err_d = 1'b1;
      end
      SRC_JR: begin
        pc_d = in_a;
      end
      SRC_JUMP: begin
        pc_d = jmp_pc;
        if (in_JAL) begin
          // A push when full overwrites the oldest slot, which is exactly
          // the slot the write pointer has wrapped around to.
          ras_d[ptr_q] = seq_pc;
          ptr_d        = ptr_q + PTR_W'(1);
          if (!ras_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SRC_BRANCH: begin
        pc_d = br_pc;
      end
      default: begin
        pc_d = seq_pc;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge in_CLOCK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      pc_q  <= RESET_ADDR;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign out_pcout     = pc_q;
  assign out_epc       = epc_q;
  assign out_ras_top   = top_pc;
  assign out_ras_empty = ras_empty;
  assign out_ras_full  = ras_full;
  assign out_ras_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer: directed scenarios from
//             the block requirements followed by randomized traffic checked
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int RAS_D = 4;

  logic        clk;
  logic        rst_n;
  logic        en, beq, bne, bgez, equal, ge_zero;
  logic        j, jal, jr, ret, eret, force_i;
  logic [31:0] faddr, ext, a, is_w;
  logic [31:0] pcout, epc, ras_top;
  logic        js, ras_empty, ras_full, ras_err;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_err;
  logic [31:0] m_ras[$];

  pc_sequencer #(
    .WIDTH     (32),
    .RESET_ADDR(32'h0),
    .RAS_DEPTH (RAS_D),
    .INST_BYTES(4)
  ) dut (
    .in_CLOCK     (clk),
    .in_RST_N     (rst_n),
    .in_EN        (en),
    .in_BEQ       (beq),
    .in_BNE       (bne),
    .in_BGEZ      (bgez),
    .in_equal     (equal),
    .in_ge_zero   (ge_zero),
    .in_J         (j),
    .in_JAL       (jal),
    .in_JR        (jr),
    .in_RET       (ret),
    .in_ERET      (eret),
    .in_force     (force_i),
    .in_faddr     (faddr),
    .in_extended  (ext),
    .in_a         (a),
    .in_is        (is_w),
    .out_pcout    (pcout),
    .out_JS       (js),
    .out_epc      (epc),
    .out_ras_top  (ras_top),
    .out_ras_empty(ras_empty),
    .out_ras_full (ras_full),
    .out_ras_err  (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b1; beq = 1'b0; bne = 1'b0; bgez = 1'b0; equal = 1'b0; ge_zero = 1'b0;
    j = 1'b0; jal = 1'b0; jr = 1'b0; ret = 1'b0; eret = 1'b0; force_i = 1'b0;
    faddr = '0; ext = '0; a = '0; is_w = '0;
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_err = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_state(input string where);
    logic [31:0] top;
    top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    check({where, ".pc"},    pcout,                32'(m_pc));
    check({where, ".epc"},   epc,                  m_epc);
    check({where, ".top"},   ras_top,              top);
    check({where, ".empty"}, {31'b0, ras_empty},   {31'b0, m_ras.size() == 0});
    check({where, ".full"},  {31'b0, ras_full},    {31'b0, m_ras.size() == RAS_D});
    check({where, ".err"},   {31'b0, ras_err},     {31'b0, m_err});
  endtask

  // One clock step: check the redirect flag on the settled inputs, predict
  // the next architectural state from the rules, take the edge, compare.
  task automatic cycle(input string where);
    logic [31:0] seq, bt, jt, npc, nepc;
    logic        exp_js, taken, nerr;
    #1;
    seq   = m_pc + 32'd4;
    bt    = seq + (ext << 2);
    jt    = {m_pc[31:28], is_w[25:0], 2'b00};
    taken = (beq & equal) | (bne & ~equal) | (bgez & ge_zero);
    npc = seq; nepc = m_epc; exp_js = 1'b1; nerr = 1'b0;
    if (force_i) begin
      npc = faddr; nepc = m_pc;
    end else if (!en) begin
      npc = m_pc; exp_js = 1'b0;
    end else if (eret) begin
      npc = m_epc;
    end else if (ret) begin
      if (m_ras.size() > 0) npc = m_ras.pop_back();
      else begin npc = a; nerr = 1'b1; end
    end else if (jr) begin
      npc = a;
    end else if (j || jal) begin
      npc = jt;
      if (jal) begin
        m_ras.push_back(seq);
        if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
      end
    end else if (taken) begin
      npc = bt;
    end else begin
      exp_js = 1'b0;
    end
    check({where, ".js"}, {31'b0, js}, {31'b0, exp_js});
    @(posedge clk);
    #1;
    m_pc = npc; m_epc = nepc; m_err = nerr;
    check_state(where);
  endtask

  task automatic async_reset(input string where);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state(where);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    idle_inputs();
    jr = 1'b1; a = target;
    cycle("goto");
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state("reset");

    // Sequential stepping out of reset
    for (int i = 1; i <= 3; i++) begin
      cycle("seq");
      check("seq_exp", pcout, 32'(i * 4));
    end

    // Branch taken backwards / not taken
    goto_pc(32'h10);
    beq = 1'b1; equal = 1'b1; ext = 32'hFFFF_FFFE;
    cycle("beq_t");
    check("beq_t_exp", pcout, 32'h0C);
    goto_pc(32'h10);
    beq = 1'b1; equal = 1'b0; ext = 32'hFFFF_FFFE;
    cycle("beq_nt");
    check("beq_nt_exp", pcout, 32'h14);

    // JAL then RET
    goto_pc(32'h100);
    jal = 1'b1; is_w = 32'h40;
    cycle("jal");
    check("jal_top_exp", ras_top, 32'h104);
    idle_inputs(); ret = 1'b1;
    cycle("ret");
    check("ret_exp", pcout, 32'h104);

    // Five calls into a four-deep stack, then five returns
    goto_pc(32'h0);
    for (int i = 1; i <= 5; i++) begin
      idle_inputs(); jal = 1'b1; is_w = 32'(i * 4);
      cycle("jal5");
    end
    check("ras_full_exp", {31'b0, ras_full}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); ret = 1'b1; a = 32'h0000_777C;
      cycle("ret5");
      if (i < 4) check("ret5_exp", pcout, 32'h44 - 32'(i * 16));
    end
    check("underflow_pc", pcout, 32'h0000_777C);
    check("underflow_err", {31'b0, ras_err}, 32'h1);

    // Exception entry during stall, then exception return
    goto_pc(32'h200);
    en = 1'b0; force_i = 1'b1; faddr = 32'h8000;
    cycle("force");
    check("force_epc_exp", epc, 32'h200);
    idle_inputs(); eret = 1'b1;
    cycle("eret");
    check("eret_exp", pcout, 32'h200);

    // Wrap-around, then asynchronous reset between edges
    goto_pc(32'hFFFF_FFFC);
    cycle("wrap");
    check("wrap_exp", pcout, 32'h0);
    cycle("wrap2");
    async_reset("areset");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] off;
      idle_inputs();
      en      = ($urandom_range(0, 9) != 0);
      beq     = ($urandom_range(0, 5) == 0);
      bne     = ($urandom_range(0, 5) == 0);
      bgez    = ($urandom_range(0, 5) == 0);
      equal   = $urandom_range(0, 1) == 1;
      ge_zero = $urandom_range(0, 1) == 1;
      j       = ($urandom_range(0, 11) == 0);
      jal     = ($urandom_range(0, 5) == 0);
      jr      = ($urandom_range(0, 11) == 0);
      ret     = ($urandom_range(0, 4) == 0);
      eret    = ($urandom_range(0, 19) == 0);
      force_i = ($urandom_range(0, 24) == 0);
      faddr   = $urandom & 32'hFFFF_FFFC;
      a       = $urandom & 32'hFFFF_FFFC;
      is_w    = $urandom;
      off     = 16'($urandom);
      ext     = {{16{off[15]}}, off};
      if ($urandom_range(0, 99) == 0) async_reset("rnd_reset");
      else cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: in_CLOCK (rising edge) and in_RST_N.
REQ-002 Parameter WIDTH, default 32: PC/operand width, legal range 32 or more.
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded at reset.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2 to 16.
REQ-005 Parameter INST_BYTES, default 4: sequential PC increment.
REQ-006 Port in_CLOCK, in, 1: clock.
REQ-007 Port in_RST_N, in, 1: async reset, active low.
REQ-008 Port in_EN, in, 1: advance enable; low means stall.
REQ-009 Ports in_BEQ, in_BNE, in_BGEZ, in, 1 each: conditional-branch decode.
REQ-010 Ports in_equal and in_ge_zero, in, 1 each: ALU A==B, and A>=0 signed.
REQ-011 Ports in_J, in_JAL, in_JR, in_RET, in_ERET, in, 1 each: absolute jump, jump-and-link, register jump, return, exception return.
REQ-012 Port in_force, in, 1: exception/interrupt entry. Port in_faddr, in, WIDTH: handler address.
REQ-013 Port in_extended, in, WIDTH: sign-extended branch offset, in words.
REQ-014 Port in_a, in, WIDTH: register-jump target. Port in_is, in, 32: current instruction word.
REQ-015 Port out_pcout, out, WIDTH: registered PC.
REQ-016 Port out_JS, out, 1: combinational redirect flag (flush request).
REQ-017 Port out_epc, out, WIDTH: registered exception PC.
REQ-018 Port out_ras_top, out, WIDTH: current stack top, 0 when empty.
REQ-019 Ports out_ras_empty and out_ras_full, out, 1 each: stack status.
REQ-020 Port out_ras_err, out, 1: registered one-cycle pulse on underflow.

Function
REQ-021 Sequential PC: SEQ = PC + INST_BYTES, computed modulo 2^WIDTH with wrap-around.
REQ-022 Branch target: BT = SEQ + (in_extended << 2), modulo 2^WIDTH.
REQ-023 Jump target: JT = {PC[WIDTH-1:28], in_is[25:0], 2'b00}.
REQ-024 Branch taken: (in_BEQ & in_equal) | (in_BNE & ~in_equal) | (in_BGEZ & in_ge_zero).
REQ-025 Next-PC priority on each in_CLOCK edge, highest first:
- in_force: PC <= in_faddr, out_epc <= PC; in_EN is ignored.
- in_EN low: PC, stack and out_epc hold.
- in_ERET: PC <= out_epc.
- in_RET: PC <= stack top, with a pop; on empty, PC <= in_a and out_ras_err pulses.
- in_JR: PC <= in_a.
- in_J or in_JAL: PC <= JT; in_JAL also pushes SEQ.
- Branch taken: PC <= BT.
- Otherwise: PC <= SEQ.
REQ-026 out_JS SHALL be 1 whenever the selected source is anything other than SEQ or hold. It is combinational and also asserts during a stall with in_force.
REQ-027 A push when full SHALL overwrite the oldest entry (circular). Count saturates at RAS_DEPTH and out_ras_full stays 1; no error is raised.
REQ-028 A pop when empty SHALL leave the pointer and count unchanged.
REQ-029 Push and pop never occur in the same cycle, because in_JAL and in_RET are mutually exclusive by priority.
REQ-030 Multiple decode inputs asserted together SHALL resolve strictly by the REQ-025 priority; the lower-priority request is dropped.
REQ-031 Latency: the new PC is visible on out_pcout one cycle after the deciding edge; out_ras_* reflect the post-edge state.

Reset
REQ-032 in_RST_N low SHALL asynchronously set out_pcout=RESET_ADDR, out_epc=0, stack count=0, pointer=0, out_ras_err=0, out_ras_empty=1, out_ras_full=0.
REQ-033 Reset asserted mid-stall or mid-exception SHALL discard all pending state. The first post-release edge applies REQ-025 from RESET_ADDR.

Verification
REQ-034 Release reset, in_EN=1, no decode for 3 edges -> out_pcout 0x0, 0x4, 0x8, 0xC.
REQ-035 PC=0x10, in_BEQ=1, in_equal=1, in_extended=0xFFFFFFFE -> next PC 0x0C and out_JS=1. Same stimulus with in_equal=0 -> next PC 0x14 and out_JS=0.
REQ-036 PC=0x100, in_JAL=1, in_is[25:0]=0x40 -> PC 0x100 and out_ras_top=0x104. Then in_RET -> PC 0x104 and out_ras_empty=1.
REQ-037 RAS_DEPTH=4: five JALs from PCs 0x0, 0x10, 0x20, 0x30, 0x40, then five RETs -> targets 0x44, 0x34, 0x24, 0x14, then in_a, with an out_ras_err pulse on the fifth RET.
REQ-038 PC=0x200, in_EN=0, in_force=1, in_faddr=0x8000 -> PC 0x8000 and out_epc=0x200. Then in_ERET with in_EN=1 -> PC 0x200.
REQ-039 PC=0xFFFFFFFC, sequential step -> PC 0x0. Pull in_RST_N low between edges -> out_pcout goes to 0 immediately, without waiting for a clock edge.
